freq_div_controller: RTL and testbench
======================================

Name: freq_div_controller

Overview:
- Frequency-selection controller and programmable divider for the 3-bit frequency-code path.
- Holds the current frequency code, driven by up/down/load requests, and drives it out on FREC to an external combinational decoder. That decoder returns the 7-bit divide constant on DIV_IN.
- Generates a divided square wave and enable pulse, and switches the divide constant only at a full-period boundary, so no runt half-periods occur.

Parameters:
- CODE_W, 3, frequency-code width.
- DIV_W, 7, divide-constant width.
- RESET_CODE, 0, frequency code after reset.
- RESET_DIV, 79, active divide constant after reset; matches the decode of RESET_CODE.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- RUN  in  1  divider run enable; synchronous level.
- UP  in  1  increment code request; one-cycle pulse.
- DOWN  in  1  decrement code request; one-cycle pulse.
- LOAD  in  1  load LOAD_CODE request; one-cycle pulse.
- LOAD_CODE  in  CODE_W  code to load.
- DIV_IN  in  DIV_W  divide constant decoded from FREC, combinational return path.
- FREC  out  CODE_W  registered target frequency code.
- CLK_OUT  out  1  divided square wave.
- CLK_EN  out  1  one-cycle pulse on each CLK_OUT rising toggle.
- BUSY  out  1  a code change is pending, not yet applied.
- CHG_DONE  out  1  one-cycle pulse when a new divide constant takes effect.

Behaviour:
- Reset (async, RST_N=0):
  - FREC=RESET_CODE, div_active=RESET_DIV, cnt=0.
  - CLK_OUT=0, CLK_EN=0, BUSY=0, CHG_DONE=0, state=IDLE.
- Request priority: LOAD > UP > DOWN. UP and DOWN together without LOAD is a no-op and is not accepted.
- Code update:
  - UP saturates at 7; DOWN saturates at 0.
  - FREC is registered on the accepting edge.
  - A request that leaves the code unchanged (saturated, or LOAD of the same value) is still accepted and runs the full change sequence.
- Counter:
  - cnt runs 0..div_active.
  - At cnt==div_active: cnt<=0 and CLK_OUT toggles.
  - Half-period = div_active+1 cycles; period = 2*(div_active+1). Div=79 gives 160 cycles.
- CLK_EN is registered high for exactly one cycle, on the same edge CLK_OUT goes 0->1.
- Boundary: terminal count while CLK_OUT==1, i.e. the falling toggle.
- State machine:
  - IDLE: on accepted request -> SETTLE, BUSY<=1.
  - SETTLE (exactly 1 cycle, lets DIV_IN settle from the new FREC): a new request stays in SETTLE for one more cycle; otherwise -> ARMED.
  - ARMED: wait for boundary. A new request -> SETTLE, so the last request wins.
  - Apply, at the boundary edge in ARMED with no request: div_active<=DIV_IN, cnt<=0, CLK_OUT<=0, CHG_DONE<=1 for one cycle, BUSY<=0, -> IDLE.
  - A request on the boundary edge takes priority: -> SETTLE with no apply; the change is applied at the next boundary.
- RUN=0:
  - cnt held at 0, CLK_OUT forced 0, CLK_EN 0.
  - In ARMED, apply on the next edge without waiting for a boundary.
  - Requests are still accepted.
- RUN 0->1: counting starts from cnt=0 with CLK_OUT=0; the first rising toggle comes after div_active+1 cycles.
- A DIV_IN value of 0 is legal: half-period of 1 cycle, so CLK_OUT toggles every cycle.
- Reset mid-change discards the pending change; FREC returns to RESET_CODE.

Decomposition:
- Shared package holds:
  - CODE_W and DIV_W.
  - RESET_CODE and RESET_DIV constants.
  - State encoding IDLE/SETTLE/ARMED as a 2-bit enumerated constant set.
  - Code min/max constants (0, 7).
- One natural sub-module: half_period_counter.
  - Contains cnt, the CLK_OUT toggle, CLK_EN generation and the RUN gating.
  - Exposes a boundary flag and a load strobe for the new divide constant.
- Request arbitration, FREC register and the FSM stay in freq_div_controller.
- The decoder stays outside; the testbench models it with the table 0..7 -> 79,47,31,23,19,15,13,11.

Test Plan:
- Reset then RUN=1 -> CLK_OUT high 80 / low 80 cycles; CLK_EN every 160 cycles; FREC=0; BUSY=0.
- One UP pulse mid-high-phase -> FREC=1 next edge, BUSY=1. At the falling boundary: CHG_DONE pulse, BUSY=0. Subsequent half-periods are 48 cycles.
- FREC=7 plus UP -> FREC stays 7; sequence still runs with CHG_DONE at boundary; half-period stays 12. DOWN from 0 behaves the same way at the low end.
- LOAD=1 with LOAD_CODE=5 and UP=1 on the same cycle -> FREC=5; half-period 16 after the boundary. UP+DOWN alone -> no change, BUSY stays 0.
- UP, then DOWN while ARMED, then LOAD_CODE=3 on the boundary edge -> no apply at that boundary. FREC=3; applied at the following boundary; half-period 24.
- RUN=0 with ARMED pending -> apply next edge, CLK_OUT=0. Separately, RST_N low mid-ARMED -> all outputs at reset values immediately, asynchronously, and FREC=0.

Source files
------------

// File: rtl/freq_div_controller_pkg.sv
// freq_div_controller_pkg: shared widths, reset constants, code limits, FSM states and code-step helper
package freq_div_controller_pkg;
    localparam int CODE_W = 3;
    localparam int DIV_W  = 7;
    localparam logic [CODE_W-1:0] RESET_CODE = 3'd0;
    localparam logic [DIV_W-1:0]  RESET_DIV  = 7'd79;
    localparam logic [CODE_W-1:0] CODE_MIN   = 3'd0;
    localparam logic [CODE_W-1:0] CODE_MAX   = 3'd7;

    typedef enum logic [1:0] {IDLE, SETTLE, ARMED} state_t;

    // LOAD beats UP beats DOWN; UP with DOWN (no LOAD) leaves the code alone.
    function automatic logic [CODE_W-1:0] next_code(
        input logic [CODE_W-1:0] cur,
        input logic              up,
        input logic              down,
        input logic              load,
        input logic [CODE_W-1:0] load_code
    );
        return load ? load_code
             : (up && !down) ? (cur == CODE_MAX ? cur : cur + 1'b1)
             : (down && !up) ? (cur == CODE_MIN ? cur : cur - 1'b1)
             : cur;
    endfunction
endpackage

// File: rtl/freq_div_controller_half_period_counter.sv
// half_period_counter: divide counter producing clk_out/clk_en, with run gating and divide-constant load
// Ports: clk, rst_n (async, active-low), run (count enable), load (take div_new now),
//        div_new (new divide constant), boundary (falling-toggle edge is next),
//        clk_out (divided square wave), clk_en (pulse on each rising toggle)
module half_period_counter
    import freq_div_controller_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             load,
    input  logic [DIV_W-1:0] div_new,
    output logic             boundary,
    output logic             clk_out,
    output logic             clk_en
);
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_active;
    logic             terminal;

    assign terminal = cnt == div_active;
    assign boundary = run && terminal && clk_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_active <= RESET_DIV;
            cnt        <= '0;
            clk_out    <= 1'b0;
            clk_en     <= 1'b0;
        end else if (load) begin
            // restart a fresh low phase with the new constant
            div_active <= div_new;
            cnt        <= '0;
            clk_out    <= 1'b0;
            clk_en     <= 1'b0;
        end else if (!run) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            clk_en  <= 1'b0;
        end else begin
            cnt     <= terminal ? '0 : cnt + 1'b1;
            clk_out <= clk_out ^ terminal;
            clk_en  <= terminal && !clk_out;
        end
    end
endmodule

// File: rtl/freq_div_controller.sv
// freq_div_controller: frequency-code register with glitch-free divide-constant switching
// Ports: clk, rst_n (async, active-low), run, up/down/load (one-cycle requests), load_code,
//        div_in (decoded constant for frec), frec (code to decoder), clk_out, clk_en,
//        busy (change pending), chg_done (pulse when new constant takes effect)
module freq_div_controller
    import freq_div_controller_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              up,
    input  logic              down,
    input  logic              load,
    input  logic [CODE_W-1:0] load_code,
    input  logic [DIV_W-1:0]  div_in,
    output logic [CODE_W-1:0] frec,
    output logic              clk_out,
    output logic              clk_en,
    output logic              busy,
    output logic              chg_done
);
    state_t state, state_next;
    logic   accept, apply, boundary;

    assign accept = load || (up != down);
    assign busy   = state != IDLE;

    // SETTLE gives div_in one full cycle to follow frec; a newer request restarts it.
    always_comb begin
        apply      = 1'b0;
        state_next = state;
        apply      = state == ARMED && !accept && (boundary || !run);
        state_next = accept ? SETTLE : state == SETTLE ? ARMED : apply ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            frec     <= RESET_CODE;
            chg_done <= 1'b0;
        end else begin
            state    <= state_next;
            frec     <= next_code(frec, up, down, load, load_code);
            chg_done <= apply;
        end
    end

    half_period_counter u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .load     (apply),
        .div_new  (div_in),
        .boundary (boundary),
        .clk_out  (clk_out),
        .clk_en   (clk_en)
    );
endmodule

// File: tb/tb_freq_div_controller.sv
// tb_freq_div_controller: directed and random checks of freq_div_controller against a behavioural model
module tb_freq_div_controller;
    import freq_div_controller_pkg::*;

    logic       clk = 0, rst_n = 0, run = 0, up = 0, down = 0, load = 0;
    logic [2:0] load_code = 0;
    logic [6:0] div_in;
    logic [2:0] frec;
    logic       clk_out, clk_en, busy, chg_done;
    int         compared = 0, mismatched = 0;
    bit         zero_mode = 0;
    int         tbl[8] = '{79, 47, 31, 23, 19, 15, 13, 11};

    always #5 clk = !clk;

    // external decoder; zero_mode maps code 7 to the legal constant 0
    assign div_in = (zero_mode && frec == 3'd7) ? 7'd0 : 7'(tbl[frec]);

    freq_div_controller dut (
        .clk(clk), .rst_n(rst_n), .run(run), .up(up), .down(down), .load(load),
        .load_code(load_code), .div_in(div_in), .frec(frec), .clk_out(clk_out),
        .clk_en(clk_en), .busy(busy), .chg_done(chg_done)
    );

    task automatic chk(string name, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dec(int c);
        return (zero_mode && c == 7) ? 0 : tbl[c];
    endfunction

    // Model: code, active divide, cycles elapsed in the current half period, output level,
    // and a pending change that may land once two edges have passed since the last request.
    int m_code = 0, m_div = 79, m_el = 0, m_since = 0;
    bit m_clk = 0, m_en = 0, m_done = 0, m_pend = 0, m_acc, m_app;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_code = 0; m_div = 79; m_el = 0; m_since = 0;
            m_clk = 0; m_en = 0; m_done = 0; m_pend = 0;
        end else begin
            m_acc = load || (up != down);
            m_app = m_pend && !m_acc && m_since >= 1 && (!run || (m_clk && m_el == m_div));
            m_en = 0;
            m_done = m_app;
            if (m_app) begin
                m_div = dec(m_code); m_el = 0; m_clk = 0; m_pend = 0;
            end else if (!run) begin
                m_el = 0; m_clk = 0;
            end else if (m_el == m_div) begin
                m_el = 0; m_en = !m_clk; m_clk = !m_clk;
            end else begin
                m_el++;
            end
            if (m_acc) begin
                m_code = load ? int'(load_code) : up ? (m_code == 7 ? 7 : m_code + 1)
                                                     : (m_code == 0 ? 0 : m_code - 1);
                m_pend = 1;
                m_since = 0;
            end else if (m_since < 1000) begin
                m_since++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("frec", int'(frec), m_code);
            chk("clk_out", int'(clk_out), int'(m_clk));
            chk("clk_en", int'(clk_en), int'(m_en));
            chk("busy", int'(busy), int'(m_pend));
            chk("chg_done", int'(chg_done), int'(m_done));
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(bit u, bit d, bit l, logic [2:0] c);
        @(negedge clk);
        up = u; down = d; load = l; load_code = c;
        @(negedge clk);
        up = 0; down = 0; load = 0;
    endtask

    task automatic wait_clk(logic v, output int n);
        n = 0;
        while (clk_out !== v && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic level_len(string name, int exp);
        int n;
        logic v;
        v = clk_out;
        wait_clk(!v, n);
        chk(name, n, exp);
    endtask

    task automatic wait_done(string name);
        int n;
        n = 0;
        while (chg_done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(chg_done), 1);
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_frec"}, int'(frec), 0);
        chk({tag, "_clk_out"}, int'(clk_out), 0);
        chk({tag, "_clk_en"}, int'(clk_en), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_chg_done"}, int'(chg_done), 0);
    endtask

    initial begin
        int n;
        step(3);
        chk_reset("rst");
        rst_n = 1;
        run = 1;
        wait_clk(1, n);
        chk("first_rise", n, 80);
        chk("first_en", int'(clk_en), 1);
        level_len("high_80", 80);
        level_len("low_80", 80);
        chk("idle_frec", int'(frec), 0);
        chk("idle_busy", int'(busy), 0);

        step(40);
        pulse(1, 0, 0, 0);
        chk("up_frec", int'(frec), 1);
        chk("up_busy", int'(busy), 1);
        wait_done("up_done");
        chk("up_done_clk_out", int'(clk_out), 0);
        chk("up_done_busy", int'(busy), 0);
        level_len("half_48a", 48);
        level_len("half_48b", 48);

        pulse(0, 0, 1, 7);
        wait_done("ld7_done");
        pulse(1, 0, 0, 0);
        chk("sat_hi_frec", int'(frec), 7);
        chk("sat_hi_busy", int'(busy), 1);
        wait_done("sat_hi_done");
        level_len("half_12", 12);
        pulse(0, 0, 1, 0);
        wait_done("ld0_done");
        pulse(0, 1, 0, 0);
        chk("sat_lo_frec", int'(frec), 0);
        wait_done("sat_lo_done");
        level_len("half_80", 80);

        pulse(1, 0, 1, 5);
        chk("load_prio_frec", int'(frec), 5);
        wait_done("load_prio_done");
        level_len("half_16", 16);
        pulse(1, 1, 0, 0);
        chk("updown_busy", int'(busy), 0);
        chk("updown_frec", int'(frec), 5);

        wait_clk(0, n);
        wait_clk(1, n);
        pulse(1, 0, 0, 0);
        chk("lw_up_frec", int'(frec), 6);
        step(3);
        pulse(0, 1, 0, 0);
        chk("lw_down_frec", int'(frec), 5);
        step(7);
        pulse(0, 0, 1, 3);
        chk("bnd_clk_out", int'(clk_out), 0);
        chk("bnd_no_done", int'(chg_done), 0);
        chk("bnd_busy", int'(busy), 1);
        chk("bnd_frec", int'(frec), 3);
        wait_done("bnd_next_done");
        level_len("half_24", 24);

        pulse(1, 0, 0, 0);
        step(1);
        run = 0;
        @(negedge clk);
        chk("run0_done", int'(chg_done), 1);
        chk("run0_clk_out", int'(clk_out), 0);
        chk("run0_busy", int'(busy), 0);
        chk("run0_frec", int'(frec), 4);
        step(5);
        chk("run0_hold_clk", int'(clk_out), 0);
        chk("run0_hold_en", int'(clk_en), 0);
        run = 1;
        level_len("run1_half_20", 20);

        zero_mode = 1;
        pulse(0, 0, 1, 7);
        wait_done("zero_done");
        level_len("half_1a", 1);
        level_len("half_1b", 1);

        zero_mode = 0;
        pulse(0, 1, 0, 0);
        step(1);
        #2 rst_n = 0;
        #1 chk_reset("async_rst");
        @(negedge clk);
        rst_n = 1;

        zero_mode = bit'($urandom_range(0, 1));
        repeat (4000) begin
            @(negedge clk);
            up = ($urandom_range(0, 39) == 0);
            down = ($urandom_range(0, 39) == 0);
            load = ($urandom_range(0, 59) == 0);
            load_code = 3'($urandom);
            if ($urandom_range(0, 199) == 0) run = !run;
        end
        up = 0; down = 0; load = 0;
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
